// File: rtl/demux_pkg.sv
// Shared types and defaults for the registered 1-to-N demultiplexer.
package demux_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_CH_DEF = 6;

  typedef logic [2:0]            sel_t;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register: fills on fill_i, empties when drain_rdy is seen while full.
module demux_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              drain_rdy,
  output logic              full,
  output logic [DATA_W-1:0] data
);
  logic              full_d, full_q;
  logic [DATA_W-1:0] data_d, data_q;

  // A fill in the same cycle as a drain keeps the slot full with the new word.
  always_comb begin
    full_d = fill_i | (full_q & ~drain_rdy);
    data_d = fill_i ? fill_data : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
endmodule

// File: rtl/reg_demux32_6.sv
// Registered demux: routes one upstream word to one of NUM_CH single-entry slots.
// Optional DEMUX_SEL_ERR_EN: out-of-range selectors drop the word and set sticky err.
module reg_demux32_6
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [2:0]               in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [2:0]               occ_count,
  output logic                     err
);
  localparam sel_t NUM_CH_SEL = sel_t'(NUM_CH);

  sel_t              eff_sel;
  logic              in_range;
  logic              accept;
  logic              write_en;
  logic [NUM_CH-1:0] fill;
  logic [NUM_CH-1:0] full_nxt;
  logic [2:0]        occ_d, occ_q;

  always_comb begin
    in_range = (in_sel < NUM_CH_SEL);
    eff_sel  = in_range ? in_sel : '0;
    in_ready = ~out_valid[eff_sel] | out_ready[eff_sel];
`ifdef DEMUX_SEL_ERR_EN
    if (!in_range) in_ready = 1'b1;
`endif
    accept   = in_valid & in_ready;
`ifdef DEMUX_SEL_ERR_EN
    write_en = accept & in_range;
`else
    write_en = accept;
`endif
    fill          = '0;
    fill[eff_sel] = write_en;
    // Count from the slots' next state so fill+drain on one edge nets to no change.
    full_nxt = fill | (out_valid & ~out_ready);
    occ_d    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      occ_d = occ_d + {2'b00, full_nxt[k]};
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill_i    (fill[k]),
      .fill_data (in_data),
      .drain_rdy (out_ready[k]),
      .full      (out_valid[k]),
      .data      (out_data[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occ_q <= '0;
    else          occ_q <= occ_d;
  end

  assign occ_count = occ_q;

`ifdef DEMUX_SEL_ERR_EN
  logic err_d, err_q;

  always_comb begin
    err_d = err_q | (accept & ~in_range);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_reg_demux32_6.sv
// Randomized + directed bench for reg_demux32_6 against an array-based slot model.
module tb_reg_demux32_6;
  localparam int DW = 32;
  localparam int NC = 6;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [2:0]       in_sel = '0;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready = '0;
  logic [NC*DW-1:0] out_data;
  logic [2:0]       occ_count;
  logic             err;

  reg_demux32_6 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occ_count(occ_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] dout(input int k);
    return out_data[k*DW +: DW];
  endfunction

  // Reference model: one flag and one word per channel, plus sticky error.
  logic          mfull [NC];
  logic [DW-1:0] mdata [NC];
  logic          merr;
  logic [DW-1:0] ch2_log [$];

  function automatic logic exp_ready(input logic [2:0] s, input logic [NC-1:0] r);
    int e;
    if (int'(s) < NC) e = int'(s);
    else begin
`ifdef DEMUX_SEL_ERR_EN
      return 1'b1;
`else
      e = 0;
`endif
    end
    return !mfull[e] || r[e];
  endfunction

  function automatic logic [NC-1:0] exp_valid();
    logic [NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k] = mfull[k];
    return v;
  endfunction

  function automatic int exp_occ();
    int c = 0;
    for (int k = 0; k < NC; k++) c += mfull[k] ? 1 : 0;
    return c;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NC; k++) begin
        mfull[k] = 1'b0;
        mdata[k] = '0;
      end
      merr = 1'b0;
    end else begin
      logic rdy;
      rdy = exp_ready(in_sel, out_ready);
      if (out_valid[2] && out_ready[2]) ch2_log.push_back(out_data[2*DW +: DW]);
      for (int k = 0; k < NC; k++) if (mfull[k] && out_ready[k]) mfull[k] = 1'b0;
      if (in_valid && rdy) begin
        if (int'(in_sel) < NC) begin
          mfull[in_sel] = 1'b1;
          mdata[in_sel] = in_data;
        end else begin
`ifdef DEMUX_SEL_ERR_EN
          merr = 1'b1;
`else
          mfull[0] = 1'b1;
          mdata[0] = in_data;
`endif
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    chk("cyc_out_valid", 192'(out_valid), 192'(exp_valid()));
    chk("cyc_occ_count", 192'(occ_count), 192'(exp_occ()));
    chk("cyc_err", 192'(err), 192'(merr));
    chk("cyc_in_ready", 192'(in_ready), 192'(exp_ready(in_sel, out_ready)));
    for (int k = 0; k < NC; k++)
      if (mfull[k]) chk("cyc_out_data", 192'(dout(k)), 192'(mdata[k]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int cyc;
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_out_data", 192'(out_data), 192'(0));
    chk("rst_occ", 192'(occ_count), 192'(0));
    chk("rst_err", 192'(err), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    #1 reset_n = 1'b1;

    // Idle routing
    in_valid = 1; in_sel = 3; in_data = 32'hDEADBEEF; out_ready = '0;
    #1 chk("idle_in_ready", 192'(in_ready), 192'(1));
    step();
    in_valid = 0;
    chk("idle_out_valid", 192'(out_valid), 192'(6'b001000));
    chk("idle_data3", 192'(dout(3)), 192'(32'hDEADBEEF));
    chk("idle_occ", 192'(occ_count), 192'(1));

    // Back-pressure then drain-and-refill on the same edge
    in_valid = 1; in_sel = 3; in_data = 32'h11111111;
    #1 chk("bp_in_ready_low", 192'(in_ready), 192'(0));
    step();
    chk("bp_hold_data", 192'(dout(3)), 192'(32'hDEADBEEF));
    out_ready = 6'b001000;
    #1 chk("bp_in_ready_high", 192'(in_ready), 192'(1));
    step();
    in_valid = 0; out_ready = '0;
    chk("bp_new_data", 192'(dout(3)), 192'(32'h11111111));
    chk("bp_out_valid", 192'(out_valid), 192'(6'b001000));
    chk("bp_occ", 192'(occ_count), 192'(1));
    out_ready = 6'b001000;
    step();
    out_ready = '0;

    // Parallel drain
    for (int i = 0; i < NC; i++) begin
      in_valid = 1; in_sel = 3'(i); in_data = 32'h10 + 32'(i);
      step();
    end
    in_valid = 0;
    chk("par_occ_full", 192'(occ_count), 192'(6));
    chk("par_valid_full", 192'(out_valid), 192'(6'b111111));
    chk("par_data4", 192'(dout(4)), 192'(32'h14));
    out_ready = 6'b111111;
    step();
    out_ready = '0;
    chk("par_valid_empty", 192'(out_valid), 192'(0));
    chk("par_occ_empty", 192'(occ_count), 192'(0));

    // Out-of-range selector
    in_valid = 1; in_sel = 7; in_data = 32'hA5A5A5A5;
    step();
    in_valid = 0;
`ifdef DEMUX_SEL_ERR_EN
    chk("oor_out_valid", 192'(out_valid), 192'(0));
    chk("oor_err", 192'(err), 192'(1));
    step();
    chk("oor_err_sticky", 192'(err), 192'(1));
`else
    chk("oor_out_valid", 192'(out_valid), 192'(6'b000001));
    chk("oor_data0", 192'(dout(0)), 192'(32'hA5A5A5A5));
    chk("oor_err", 192'(err), 192'(0));
    out_ready = 6'b000001;
    step();
    out_ready = '0;
`endif

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sel = 3'(i); in_data = 32'h20 + 32'(i);
      step();
    end
    in_valid = 0;
    chk("mid_occ_before", 192'(occ_count), 192'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_out_valid", 192'(out_valid), 192'(0));
    chk("mid_occ", 192'(occ_count), 192'(0));
    chk("mid_err", 192'(err), 192'(0));
    step();
    #1 reset_n = 1'b1;
    in_valid = 1; in_sel = 1; in_data = 32'h77;
    #1 chk("post_rst_in_ready", 192'(in_ready), 192'(1));
    step();
    in_valid = 0;
    chk("post_rst_valid", 192'(out_valid), 192'(6'b000010));
    chk("post_rst_occ", 192'(occ_count), 192'(1));
    out_ready = 6'b000010;
    step();
    out_ready = '0;

    // Ordering on channel 2 with random consumer
    ch2_log.delete();
    idx = 0;
    cyc = 0;
    while (cyc < 200 && ch2_log.size() < 3) begin
      in_valid = (idx < 3);
      in_sel = 2;
      in_data = 32'(idx + 1);
      out_ready = '0;
      out_ready[2] = 1'($urandom_range(0, 1));
      #1 acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) idx++;
      #1;
      cyc++;
    end
    in_valid = 0; out_ready = '0;
    chk("ord_count", 192'(ch2_log.size()), 192'(3));
    if (ch2_log.size() == 3) begin
      chk("ord_w0", 192'(ch2_log[0]), 192'(1));
      chk("ord_w1", 192'(ch2_log[1]), 192'(2));
      chk("ord_w2", 192'(ch2_log[2]), 192'(3));
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = NC'($urandom);
      step();
    end
    in_valid = 0; out_ready = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
